// File: rtl/clk_meter.sv
// Measures period and high time of a slow square wave in clk cycles and
// reports lock when consecutive periods match the expected value.
module clk_meter #(
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int EXPECT_PERIOD = 4,
    parameter int TOL           = 0,
    parameter int LOCK_COUNT    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             lock,
    output logic             overflow,
    output logic             rise_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   EXP_W   = (CNT_W+1)'(EXPECT_PERIOD);
    localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LC      = 4'(LOCK_COUNT);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_high_pending;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high_time;
    logic [3:0]             r_match_cnt;
    logic                   r_valid;
    logic                   r_lock;
    logic                   r_overflow;
    logic                   r_rise_pulse;

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W:0]         w_cnt_ext;
    logic [CNT_W:0]         w_diff;
    logic                   w_match;
    logic [3:0]             w_match_inc;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;
    assign w_fall = ~w_sync & r_prev;

    // Deviation taken one bit wider than the counter so it never wraps.
    assign w_cnt_ext   = {1'b0, r_cnt};
    assign w_diff      = (w_cnt_ext >= EXP_W) ? (w_cnt_ext - EXP_W) : (EXP_W - w_cnt_ext);
    assign w_match     = (w_diff <= TOL_W);
    assign w_match_inc = (r_match_cnt >= LC) ? LC : (r_match_cnt + 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= w_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_high_pending <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_match_cnt    <= '0;
            r_valid        <= 1'b0;
            r_lock         <= 1'b0;
            r_overflow     <= 1'b0;
            r_rise_pulse   <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_rise_pulse <= w_rise && (r_state != ST_IDLE);
            if (!meas_en) begin
                // Any partial measurement is dropped; period/high_time are kept.
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_match_cnt <= '0;
                r_lock      <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_WAIT_RISE;
                    end
                    ST_WAIT_RISE: begin
                        if (w_rise) begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_high_pending;
                            r_valid     <= 1'b1;
                            r_cnt       <= CNT_W'(1);
                            if (w_match) begin
                                r_match_cnt <= w_match_inc;
                                r_lock      <= (w_match_inc >= LC);
                            end else begin
                                r_match_cnt <= '0;
                                r_lock      <= 1'b0;
                            end
                        end else if (r_cnt == CNT_MAX) begin
                            r_overflow  <= 1'b1;
                            r_lock      <= 1'b0;
                            r_match_cnt <= '0;
                            r_state     <= ST_WAIT_RISE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (w_fall) begin
                                r_high_pending <= r_cnt;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign valid      = r_valid;
    assign lock       = r_lock;
    assign overflow   = r_overflow;
    assign rise_pulse = r_rise_pulse;

endmodule

// File: tb/tb_clk_meter.sv
// Directed bench for clk_meter: instance A (CNT_W=16, TOL=0) and instance B
// (CNT_W=4, TOL=1) share stimulus; each test checks the relevant instance.
module tb_clk_meter;

    logic clk;
    logic rst;
    logic sig_in;
    logic meas_en;

    logic [15:0] a_period, a_high;
    logic        a_valid, a_lock, a_overflow, a_rise_pulse;
    logic [3:0]  b_period, b_high;
    logic        b_valid, b_lock, b_overflow, b_rise_pulse;

    clk_meter #(.CNT_W(16), .SYNC_STAGES(2), .EXPECT_PERIOD(4), .TOL(0), .LOCK_COUNT(4)) u_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
        .period(a_period), .high_time(a_high), .valid(a_valid), .lock(a_lock),
        .overflow(a_overflow), .rise_pulse(a_rise_pulse)
    );

    clk_meter #(.CNT_W(4), .SYNC_STAGES(2), .EXPECT_PERIOD(4), .TOL(1), .LOCK_COUNT(4)) u_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
        .period(b_period), .high_time(b_high), .valid(b_valid), .lock(b_lock),
        .overflow(b_overflow), .rise_pulse(b_rise_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        int   per;
        int   hi;
        logic lk;
        logic rp;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    ev_t mon_ev;
    int  cyc      = 0;
    int  rp_cnt_a = 0;
    int  n_tests  = 0;
    int  n_fail   = 0;
    int  e_per[$];
    int  e_hi[$];
    int  e_lk[$];

    // Record every valid pulse shortly after the edge that produced it.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (a_rise_pulse) rp_cnt_a++;
        if (a_valid) begin
            mon_ev.cyc = cyc; mon_ev.per = int'(a_period); mon_ev.hi = int'(a_high);
            mon_ev.lk = a_lock; mon_ev.rp = a_rise_pulse;
            q_a.push_back(mon_ev);
        end
        if (b_valid) begin
            mon_ev.cyc = cyc; mon_ev.per = int'(b_period); mon_ev.hi = int'(b_high);
            mon_ev.lk = b_lock; mon_ev.rp = b_rise_pulse;
            q_b.push_back(mon_ev);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_period(input int h, input int l);
        sig_in = 1'b1;
        step(h);
        sig_in = 1'b0;
        step(l);
    endtask

    // Compare recorded valid events from index base onward with e_per/e_hi/e_lk.
    task automatic check_stream(input string tag, input bit use_b, input int base);
        ev_t ev;
        int  got_n;
        got_n = (use_b ? q_b.size() : q_a.size()) - base;
        check($sformatf("%s_count", tag), got_n, e_per.size());
        for (int i = 0; i < e_per.size() && i < got_n; i++) begin
            ev = use_b ? q_b[base+i] : q_a[base+i];
            check($sformatf("%s_per%0d", tag, i), ev.per, e_per[i]);
            check($sformatf("%s_hi%0d", tag, i), ev.hi, e_hi[i]);
            check($sformatf("%s_lock%0d", tag, i), ev.lk, e_lk[i]);
            check($sformatf("%s_rp%0d", tag, i), ev.rp, 1);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int rp_base;
        rst = 1'b1;
        sig_in = 1'b0;
        meas_en = 1'b0;
        step(3);
        check("rst_a_period", a_period, 0);
        check("rst_a_high", a_high, 0);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_lock", a_lock, 0);
        check("rst_a_ovf", a_overflow, 0);
        check("rst_a_rp", a_rise_pulse, 0);
        check("rst_b_period", b_period, 0);
        rst = 1'b0;
        meas_en = 1'b1;
        step(2);

        // Period 4 stream locks, then high 3 / low 5 breaks lock.
        base = q_a.size();
        rp_base = rp_cnt_a;
        repeat (6) drive_period(2, 2);
        repeat (3) drive_period(3, 5);
        step(6);
        e_per = '{4, 4, 4, 4, 4, 4, 8, 8};
        e_hi  = '{2, 2, 2, 2, 2, 2, 3, 3};
        e_lk  = '{0, 0, 0, 1, 1, 1, 0, 0};
        check_stream("t12", 1'b0, base);
        if (q_a.size() >= base + 7) begin
            check("t1_spacing", q_a[base+1].cyc - q_a[base].cyc, 4);
            check("t2_spacing", q_a[base+6].cyc - q_a[base+5].cyc, 8);
        end
        check("t12_rise_pulses", rp_cnt_a - rp_base, 9);
        check("t2_lock_end", a_lock, 0);

        // Saturation on the 4-bit instance while sig_in is held high.
        pulse_reset();
        step(3);
        base = q_b.size();
        sig_in = 1'b1;
        step(17);
        check("t3_ovf_before", b_overflow, 0);
        step(1);
        check("t3_ovf_set", b_overflow, 1);
        check("t3_lock", b_lock, 0);
        check("t3_period_held", b_period, 0);
        step(2);
        sig_in = 1'b0;
        step(2);
        repeat (3) drive_period(2, 2);
        step(4);
        e_per = '{4, 4};
        e_hi  = '{2, 2};
        e_lk  = '{0, 0};
        check_stream("t3", 1'b1, base);
        check("t3_ovf_sticky", b_overflow, 1);

        // Reset in the middle of a locked measurement.
        pulse_reset();
        step(3);
        repeat (6) drive_period(2, 2);
        step(1);
        check("t4_locked_pre", a_lock, 1);
        rst = 1'b1;
        step(1);
        check("t4_rst_period", a_period, 0);
        check("t4_rst_high", a_high, 0);
        check("t4_rst_valid", a_valid, 0);
        check("t4_rst_lock", a_lock, 0);
        check("t4_rst_ovf", a_overflow, 0);
        check("t4_rst_rp", a_rise_pulse, 0);
        rst = 1'b0;
        base = q_a.size();
        repeat (5) drive_period(2, 2);
        step(6);
        e_per = '{4, 4, 4, 4};
        e_hi  = '{2, 2, 2, 2};
        e_lk  = '{0, 0, 0, 1};
        check_stream("t4", 1'b0, base);

        // Drop meas_en for 3 cycles during lock.
        meas_en = 1'b0;
        step(3);
        check("t5_lock", a_lock, 0);
        check("t5_ovf", a_overflow, 0);
        check("t5_period", a_period, 4);
        check("t5_high", a_high, 2);
        check("t5_valid", a_valid, 0);
        meas_en = 1'b1;
        base = q_a.size();
        step(1);
        repeat (4) drive_period(2, 2);
        step(6);
        e_per = '{4, 4, 4};
        e_hi  = '{2, 2, 2};
        e_lk  = '{0, 0, 0};
        check_stream("t5", 1'b0, base);

        // Tolerance 1 on instance B: period 5 matches, period 6 does not.
        pulse_reset();
        step(3);
        base = q_b.size();
        repeat (6) drive_period(2, 3);
        repeat (2) drive_period(3, 3);
        step(6);
        e_per = '{5, 5, 5, 5, 5, 5, 6};
        e_hi  = '{2, 2, 2, 2, 2, 2, 3};
        e_lk  = '{0, 0, 0, 1, 1, 1, 0};
        check_stream("t6", 1'b1, base);
        check("t6_b_lock_end", b_lock, 0);
        check("t6_a_no_lock", a_lock, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_meter.md
Name: clk_meter

Overview:
Receive-side companion to the team's clock dividers. Samples a slow, divided clock-like signal (`sig_in`) in the fast system clock domain and measures its period and high time in system-clock cycles. Compares each measured period against an expected value and reports lock status. Used to check divider outputs on-board and as a self-checking monitor in lab designs.

Parameters:
CNT_W, 16, width of the cycle counter and of the period/high_time outputs
SYNC_STAGES, 2, number of synchronizer flops on sig_in (min 2)
EXPECT_PERIOD, 4, expected rise-to-rise period in clk cycles
TOL, 0, allowed absolute deviation |period - EXPECT_PERIOD| that still counts as a match
LOCK_COUNT, 4, consecutive matching periods required to assert lock (1..15)

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  synchronous, active-high reset
sig_in  input  1  asynchronous divided clock / square wave to measure
meas_en  input  1  measurement enable; low forces IDLE
period  output  CNT_W  last measured rise-to-rise period, in clk cycles
high_time  output  CNT_W  last measured rise-to-fall time, in clk cycles
valid  output  1  one-cycle pulse when period/high_time update
lock  output  1  high after LOCK_COUNT consecutive matching periods
overflow  output  1  sticky flag: counter saturated before the next rise
rise_pulse  output  1  one-cycle pulse on each detected synchronized rising edge

Behaviour:
- Reset (rst=1 at a clk edge): period=0, high_time=0, valid=0, lock=0, overflow=0, rise_pulse=0, state=IDLE, synchronizer flops=0, counter=0, match count=0. Reset overrides all other inputs.
- Synchronizer: sig_in passes through SYNC_STAGES flops, then one more flop (prev).
  - A rise is detected when sync=1 and prev=0; a fall when sync=0 and prev=1.
  - Detection occurs SYNC_STAGES+1 clk edges after a sig_in transition.
  - rise_pulse is registered: high the cycle after detection, in any state except IDLE.
- States:
  - IDLE: entered when meas_en=0, from any state, at the next edge. valid=0, lock=0, overflow cleared, match count=0. period and high_time hold their last values. Goes to WAIT_RISE when meas_en=1.
  - WAIT_RISE: falls are ignored. On a rise: counter<=1, go to MEASURE. No valid.
  - MEASURE: counter increments by 1 every cycle and saturates at 2^CNT_W-1.
    - On a fall: high_time_pending <= counter.
    - On a rise: period <= counter, high_time <= high_time_pending, valid <= 1 for one cycle, counter <= 1.
    - A period of N cycles rise-to-rise yields period=N; high time H yields high_time=H.
- Saturation: if counter == max and no rise this cycle:
  - overflow <= 1 (sticky until rst or IDLE), lock <= 0, match count <= 0, state <= WAIT_RISE.
  - period and high_time are not updated.
  - A rise in the same cycle that counter == max is a normal measurement (period = max).
- Lock: evaluated on each valid update.
  - Match: |counter - EXPECT_PERIOD| <= TOL, computed in CNT_W+1 bits with no wrap.
  - On a match, match count increments (saturates at LOCK_COUNT). lock is asserted in the same cycle valid is high once the count reaches LOCK_COUNT.
  - On a mismatch, match count=0 and lock=0 in the same cycle as valid.
- Latency: valid rises 1 cycle after the second and later rise detections. The first rise after WAIT_RISE never produces valid.
- If meas_en is deasserted mid-period, the partial measurement is discarded. Re-enable needs two rises before the first valid.

Test Plan:
1. EXPECT_PERIOD=4, TOL=0. meas_en=1, sig_in toggles every 2 clk -> each valid shows period=4, high_time=2. lock=1 coincident with the 4th valid. rise_pulse every 4 cycles.
2. After lock, sig_in switches to high 3 / low 5 -> first period=8 valid shows high_time=3. lock=0 in that same cycle, and lock stays 0.
3. CNT_W=4, sig_in held high after one rise -> counter reaches 15. Next edge: overflow=1, lock=0, no valid. Then toggling at period 4 gives valid only after two rises, and overflow stays 1.
4. rst pulsed for 1 cycle mid-MEASURE during a locked period-4 stream -> next cycle all outputs are 0. First valid follows the second detected rise, and lock returns after 4 valids.
5. meas_en dropped for 3 cycles during a locked stream -> lock=0 and overflow=0, period/high_time keep 4/2. After re-enable, the first valid comes after two rises.
6. TOL=1, sig_in period 5 (high 2 / low 3) -> period=5 counts as a match, lock after 4 valids. Period 6 clears lock.
